vector_lane_dispatch: RTL and testbench

- Issues one vector command at a time to all `lanes_p` lanes in parallel, then waits until every lane signals completion.
- Sits between the scalar core's command interface and the lane array. It drives each lane's op/start/scalar inputs and consumes each lane's `v_o` completion pulse.
- Reports per-command completion, or a watchdog error, back to the core through a one-cycle done pulse.

---
 rtl/vector_lane_dispatch.sv | 129 ++++++++++++
 tb/tb_vector_lane_dispatch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_lane_dispatch.sv
`default_nettype none
// vector_lane_dispatch: broadcasts one vector command to every lane, then waits
// for all lane completion pulses (or a watchdog expiry) and reports done.
module vector_lane_dispatch #(
  parameter int els_p      = 32,
  parameter int vlen_p     = 8,
  parameter int vdw_p      = 32,
  parameter int lanes_p    = 4,
  parameter int op_width_p = 3,
  parameter int timeout_p  = 64,
  localparam int v_addr_width_lp = $clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset,
  input  logic                       cmd_v_i,
  output logic                       cmd_ready_o,
  input  logic [op_width_p-1:0]      cmd_op_i,
  input  logic [v_addr_width_lp-1:0] cmd_vd_i,
  input  logic [v_addr_width_lp-1:0] cmd_vs1_i,
  input  logic [v_addr_width_lp-1:0] cmd_vs2_i,
  input  logic [vdw_p-1:0]           cmd_scalar_i,
  output logic                       lane_start_o,
  output logic [op_width_p-1:0]      lane_op_o,
  output logic [v_addr_width_lp-1:0] lane_vd_o,
  output logic [v_addr_width_lp-1:0] lane_vs1_o,
  output logic [v_addr_width_lp-1:0] lane_vs2_o,
  output logic [vdw_p-1:0]           lane_scalar_o,
  input  logic [lanes_p-1:0]         lane_v_i,
  output logic                       busy_o,
  output logic                       done_v_o,
  output logic [v_addr_width_lp-1:0] done_vd_o,
  output logic                       done_err_o
);

  localparam int timer_width_lp = $clog2(timeout_p);
  localparam logic [timer_width_lp-1:0] timer_max_lp = timer_width_lp'(timeout_p - 1);

  // The watchdog must outlast the slowest legitimate lane completion.
  if (timeout_p < vlen_p / lanes_p + 2) begin : g_timeout_check
    $error("timeout_p too small for vlen_p/lanes_p");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                    state, state_next;
  logic [lanes_p-1:0]        mask, mask_next, mask_merged;
  logic [timer_width_lp-1:0] timer, timer_next;
  logic                      err, err_next;
  logic                      accept;

  assign cmd_ready_o  = (state == IDLE);
  assign busy_o       = (state != IDLE);
  assign lane_start_o = (state == ISSUE);
  assign done_v_o     = (state == DONE);
  assign done_err_o   = (state == DONE) & err;
  assign done_vd_o    = lane_vd_o;
  assign accept       = cmd_v_i & cmd_ready_o;

  always_comb begin
    state_next  = state;
    mask_next   = mask;
    timer_next  = timer;
    err_next    = err;
    mask_merged = mask | lane_v_i;
    case (state)
      IDLE: begin
        if (cmd_v_i) state_next = ISSUE;
      end
      ISSUE: begin
        mask_next  = '0;
        timer_next = '0;
        err_next   = 1'b0;
        state_next = WAIT;
      end
      WAIT: begin
        mask_next = mask_merged;
        // Full completion takes priority over a simultaneous expiry.
        if (&mask_merged) begin
          err_next   = 1'b0;
          state_next = DONE;
        end else if (timer == timer_max_lp) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state         <= IDLE;
      mask          <= '0;
      timer         <= '0;
      err           <= 1'b0;
      lane_op_o     <= '0;
      lane_vd_o     <= '0;
      lane_vs1_o    <= '0;
      lane_vs2_o    <= '0;
      lane_scalar_o <= '0;
    end else begin
      state <= state_next;
      mask  <= mask_next;
      timer <= timer_next;
      err   <= err_next;
      if (accept) begin
        lane_op_o     <= cmd_op_i;
        lane_vd_o     <= cmd_vd_i;
        lane_vs1_o    <= cmd_vs1_i;
        lane_vs2_o    <= cmd_vs2_i;
        lane_scalar_o <= cmd_scalar_i;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vector_lane_dispatch.sv
`default_nettype none
// tb_vector_lane_dispatch: scenario tasks plus a done-pulse scoreboard.
module tb_vector_lane_dispatch;

  logic        clk_i = 1'b0;
  logic        reset;
  logic        cmd_v_i;
  logic        cmd_ready_o;
  logic [2:0]  cmd_op_i;
  logic [4:0]  cmd_vd_i, cmd_vs1_i, cmd_vs2_i;
  logic [31:0] cmd_scalar_i;
  logic        lane_start_o;
  logic [2:0]  lane_op_o;
  logic [4:0]  lane_vd_o, lane_vs1_o, lane_vs2_o;
  logic [31:0] lane_scalar_o;
  logic [3:0]  lane_v_i;
  logic        busy_o, done_v_o, done_err_o;
  logic [4:0]  done_vd_o;

  vector_lane_dispatch dut (
    .clk_i(clk_i), .reset(reset),
    .cmd_v_i(cmd_v_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
    .cmd_vd_i(cmd_vd_i), .cmd_vs1_i(cmd_vs1_i), .cmd_vs2_i(cmd_vs2_i),
    .cmd_scalar_i(cmd_scalar_i),
    .lane_start_o(lane_start_o), .lane_op_o(lane_op_o), .lane_vd_o(lane_vd_o),
    .lane_vs1_o(lane_vs1_o), .lane_vs2_o(lane_vs2_o), .lane_scalar_o(lane_scalar_o),
    .lane_v_i(lane_v_i), .busy_o(busy_o), .done_v_o(done_v_o),
    .done_vd_o(done_vd_o), .done_err_o(done_err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0] vd;
    logic       err;
    int         at;
  } exp_t;
  exp_t sb[$];

  // Every done pulse must match the oldest expected completion.
  always @(negedge clk_i) begin
    if (done_v_o === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done at cycle %0d vd=%0d err=%0b", cyc, done_vd_o, done_err_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cyc !== e.at) begin
          n_fail++;
          $display("FAIL done_cycle got %0d expected %0d", cyc, e.at);
        end
        n_checks++;
        if (done_vd_o !== e.vd) begin
          n_fail++;
          $display("FAIL done_vd got %0d expected %0d", done_vd_o, e.vd);
        end
        n_checks++;
        if (done_err_o !== e.err) begin
          n_fail++;
          $display("FAIL done_err got %0b expected %0b", done_err_o, e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic pulse_at(input int c, input logic [3:0] m);
    wait_until(c);
    lane_v_i = m;
    step();
    lane_v_i = '0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [4:0] vd, input logic [4:0] vs1,
                       input logic [4:0] vs2, input logic [31:0] sc, output int t);
    int n = 0;
    while (cmd_ready_o !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    n_checks++;
    if (n >= 200) begin
      n_fail++;
      $display("FAIL ready_wait got ready=%b expected 1 within 200 cycles", cmd_ready_o);
    end
    cmd_v_i = 1'b1; cmd_op_i = op; cmd_vd_i = vd; cmd_vs1_i = vs1; cmd_vs2_i = vs2;
    cmd_scalar_i = sc;
    t = cyc;
    step();
    cmd_v_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_v_i = 1'b1; cmd_op_i = 3'd6; cmd_vd_i = 5'd3;
    cmd_vs1_i = 5'd1; cmd_vs2_i = 5'd2; cmd_scalar_i = 32'h1234_5678; lane_v_i = '0;
    step(); step();
    n_checks++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || lane_start_o !== 1'b0 ||
        done_v_o !== 1'b0 || lane_op_o !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state got ready=%b busy=%b start=%b done=%b op=%0d expected 1 0 0 0 0",
               cmd_ready_o, busy_o, lane_start_o, done_v_o, lane_op_o);
    end
    reset = 1'b0; cmd_v_i = 1'b0;
    step();
    n_checks++;
    if (busy_o !== 1'b0 || lane_op_o !== 3'd0 || lane_vd_o !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_no_accept got busy=%b op=%0d vd=%0d expected 0 0 0",
               busy_o, lane_op_o, lane_vd_o);
    end
  endtask

  task automatic test_single();
    int t;
    issue(3'd3, 5'd5, 5'd1, 5'd2, 32'hDEAD_BEEF, t);
    sb.push_back('{vd: 5'd5, err: 1'b0, at: t + 5});
    n_checks++;
    if (lane_start_o !== 1'b1 || lane_op_o !== 3'd3 || lane_vd_o !== 5'd5 ||
        lane_vs1_o !== 5'd1 || lane_vs2_o !== 5'd2 || lane_scalar_o !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL single_start got start=%b op=%0d vd=%0d vs1=%0d vs2=%0d sc=%h expected 1 3 5 1 2 deadbeef",
               lane_start_o, lane_op_o, lane_vd_o, lane_vs1_o, lane_vs2_o, lane_scalar_o);
    end
    step();
    n_checks++;
    if (lane_start_o !== 1'b0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_wait got start=%b busy=%b expected 0 1", lane_start_o, busy_o);
    end
    pulse_at(t + 4, 4'b1111);
    wait_until(t + 6);
    n_checks++;
    if (cmd_ready_o !== 1'b1 || lane_scalar_o !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL single_ready got ready=%b sc=%h expected 1 deadbeef", cmd_ready_o, lane_scalar_o);
    end
  endtask

  task automatic test_staggered();
    int t;
    issue(3'd1, 5'd11, 5'd4, 5'd6, 32'h0000_00A5, t);
    sb.push_back('{vd: 5'd11, err: 1'b0, at: t + 8});
    pulse_at(t + 3, 4'b0101);
    pulse_at(t + 4, 4'b0001);
    pulse_at(t + 5, 4'b0010);
    pulse_at(t + 7, 4'b1000);
    wait_until(t + 9);
  endtask

  task automatic test_watchdog();
    int t;
    issue(3'd2, 5'd4, 5'd0, 5'd0, 32'h0, t);
    sb.push_back('{vd: 5'd4, err: 1'b1, at: t + 66});
    pulse_at(t + 3, 4'b0111);
    wait_until(t + 67);
    issue(3'd2, 5'd6, 5'd0, 5'd0, 32'h0, t);
    sb.push_back('{vd: 5'd6, err: 1'b0, at: t + 66});
    pulse_at(t + 3, 4'b0111);
    pulse_at(t + 65, 4'b1000);
    wait_until(t + 67);
  endtask

  task automatic test_back_to_back();
    logic exp_start[6];
    logic [4:0] exp_vd[6];
    int t;
    while (cmd_ready_o !== 1'b1) step();
    exp_start = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_vd    = '{5'd0, 5'd7, 5'd7, 5'd7, 5'd7, 5'd9};
    cmd_v_i = 1'b1; cmd_op_i = 3'd5; cmd_vd_i = 5'd7; cmd_vs1_i = 5'd2; cmd_vs2_i = 5'd3;
    t = cyc;
    sb.push_back('{vd: 5'd7, err: 1'b0, at: t + 3});
    sb.push_back('{vd: 5'd9, err: 1'b0, at: t + 7});
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 1) cmd_vd_i = 5'd9;
      lane_v_i = (i == 2) ? 4'b1111 : 4'b0000;
      if (i == 5) cmd_v_i = 1'b0;
      n_checks++;
      if (lane_start_o !== exp_start[i] || lane_vd_o !== exp_vd[i]) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d got start=%b vd=%0d expected %b %0d",
                 i, lane_start_o, lane_vd_o, exp_start[i], exp_vd[i]);
      end
    end
    pulse_at(t + 6, 4'b1111);
    wait_until(t + 8);
  endtask

  task automatic test_reset_mid_wait();
    int t;
    issue(3'd4, 5'd8, 5'd1, 5'd1, 32'hCAFE_F00D, t);
    wait_until(t + 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || lane_vd_o !== 5'd0 || lane_scalar_o !== 32'd0) begin
      n_fail++;
      $display("FAIL midreset_state got ready=%b busy=%b vd=%0d sc=%h expected 1 0 0 0",
               cmd_ready_o, busy_o, lane_vd_o, lane_scalar_o);
    end
    pulse_at(t + 5, 4'b1111);
    wait_until(t + 7);
    issue(3'd1, 5'd10, 5'd2, 5'd2, 32'h1, t);
    sb.push_back('{vd: 5'd10, err: 1'b0, at: t + 3});
    pulse_at(t + 2, 4'b1111);
    wait_until(t + 5);
  endtask

  initial begin
    test_reset();
    test_single();
    test_staggered();
    test_watchdog();
    test_back_to_back();
    test_reset_mid_wait();
    step();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
